// File: rtl/riscvibe_pkg.sv
// riscvibe_pkg: shared types for the retire-trace path.
//   trace_rec_t   : per-instruction trace record {cycle, seq, pc, instr, rd_we, rd, wdata}
//   trace_state_e : capture FSM states (CAPTURE -> DRAIN -> DONE)
//   INSTR_ECALL / INSTR_EBREAK : instruction words that end simulation
//   is_halt()     : true for ECALL or EBREAK
package riscvibe_pkg;

  localparam int          TRACE_CYCLE_W = 64;
  localparam logic [31:0] INSTR_ECALL   = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK  = 32'h0010_0073;

  typedef enum logic [1:0] {
    CAPTURE,
    DRAIN,
    DONE
  } trace_state_e;

  typedef struct packed {
    logic [TRACE_CYCLE_W-1:0] cycle;
    logic [31:0]              seq;
    logic [31:0]              pc;
    logic [31:0]              instr;
    logic                     rd_we;
    logic [4:0]               rd;
    logic [31:0]              wdata;
  } trace_rec_t;

  function automatic logic is_halt(input logic [31:0] instr);
    return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: generic synchronous FIFO with registered storage.
//   clk, rst        : clock, synchronous active-high reset
//   push, wdata     : write request; accepted when not full, or when full and popping
//   pop, rdata      : read strobe (ignored when empty); rdata is the head, read
//                     straight from storage
//   full, empty     : status
//   count           : occupancy, 0..DEPTH
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the head being popped this cycle;
  // the head is read before the edge, so the overwrite is safe.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on
      // pre-edge values, so the pointer reads in the comb logic stay consistent.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/trace_retire_buffer.sv
// trace_retire_buffer: captures WB-stage retire events into stamped trace
// records, buffers them in a FIFO and drains them to the trace logger.
//   clk, rst                 : clock, synchronous active-high reset
//   enable_i                 : capture enable (0 = retires ignored, not dropped)
//   ret_valid_i .. ret_rd_wdata_i : retire event from WB
//   rec_valid_o/rec_ready_i/rec_o : head record handshake to the logger
//   count_o                  : FIFO occupancy
//   drop_count_o             : records lost to overflow (saturating)
//   halt_seen_o              : ECALL/EBREAK has been captured
//   drained_o                : halted and FIFO empty (sticky until rst)
module trace_retire_buffer
  import riscvibe_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic                   ret_valid_i,
  input  logic [31:0]            ret_pc_i,
  input  logic [31:0]            ret_instr_i,
  input  logic                   ret_rd_we_i,
  input  logic [4:0]             ret_rd_i,
  input  logic [31:0]            ret_rd_wdata_i,
  output logic                   rec_valid_o,
  input  logic                   rec_ready_i,
  output trace_rec_t             rec_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [31:0]            drop_count_o,
  output logic                   halt_seen_o,
  output logic                   drained_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  trace_state_e     state_q, state_d;
  logic [CNT_W-1:0] cycle_q;
  logic [31:0]      seq_q;
  trace_rec_t       cap_rec;
  logic             counted;
  logic             pop;
  logic             full;
  logic             empty;
  logic             push_ok;
  logic             drop;

  // A retire is "counted" (consumes a sequence number) whenever capture is
  // live, whether or not it fits in the FIFO.
  assign counted = ret_valid_i && enable_i && (state_q == CAPTURE);
  assign pop     = rec_valid_o && rec_ready_i;
  assign push_ok = counted && (!full || pop);
  assign drop    = counted && !push_ok;
  assign rec_valid_o = !empty;

  // Writes to x0 are architecturally discarded, so they are recorded as such.
  always_comb begin
    cap_rec       = '0;
    cap_rec.cycle = TRACE_CYCLE_W'(cycle_q);
    cap_rec.seq   = seq_q;
    cap_rec.pc    = ret_pc_i;
    cap_rec.instr = ret_instr_i;
    cap_rec.rd    = ret_rd_i;
    if (ret_rd_i != 5'd0) begin
      cap_rec.rd_we = ret_rd_we_i;
      cap_rec.wdata = ret_rd_wdata_i;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(trace_rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .wdata (cap_rec),
    .pop   (pop),
    .rdata (rec_o),
    .full  (full),
    .empty (empty),
    .count (count_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CAPTURE;
      cycle_q      <= '0;
      seq_q        <= '0;
      drop_count_o <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_q + 1'b1;
      if (counted) seq_q <= seq_q + 1'b1;
      if (drop && (drop_count_o != 32'hFFFF_FFFF)) drop_count_o <= drop_count_o + 1'b1;
    end
  end

  // DRAIN finishes as soon as the FIFO will be empty after this edge, so
  // drained_o rises in the same cycle the last record has left.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_d     = state_q;
    halt_seen_o = 1'b0;
    drained_o   = 1'b0;
    case (state_q)
      CAPTURE: begin
        // A halt that is dropped while full still ends capture.
        if (counted && is_halt(ret_instr_i)) state_d = DRAIN;
      end
      DRAIN: begin
        halt_seen_o = 1'b1;
        if (empty || ((count_o == CW'(1)) && pop)) state_d = DONE;
      end
      DONE: begin
        halt_seen_o = 1'b1;
        drained_o   = 1'b1;
      end
      default: state_d = CAPTURE;
    endcase
  end

endmodule

// File: tb/tb_trace_retire_buffer.sv
// tb_trace_retire_buffer: directed self-checking bench for trace_retire_buffer.
// Inputs are driven 1 time unit after the rising edge and outputs sampled at
// the same point, away from the active edge.
module tb_trace_retire_buffer;
  import riscvibe_pkg::*;

  localparam int          DEPTH = 16;
  localparam logic [31:0] ADDI1 = 32'h0010_0093;  // addi x1, x0, 1

  logic        clk;
  logic        rst;
  logic        enable_i;
  logic        ret_valid_i;
  logic [31:0] ret_pc_i;
  logic [31:0] ret_instr_i;
  logic        ret_rd_we_i;
  logic [4:0]  ret_rd_i;
  logic [31:0] ret_rd_wdata_i;
  logic        rec_valid_o;
  logic        rec_ready_i;
  trace_rec_t  rec_o;
  logic [4:0]  count_o;
  logic [31:0] drop_count_o;
  logic        halt_seen_o;
  logic        drained_o;

  int errors = 0;
  int checks = 0;

  trace_retire_buffer #(.DEPTH(DEPTH), .CNT_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable_i),
    .ret_valid_i    (ret_valid_i),
    .ret_pc_i       (ret_pc_i),
    .ret_instr_i    (ret_instr_i),
    .ret_rd_we_i    (ret_rd_we_i),
    .ret_rd_i       (ret_rd_i),
    .ret_rd_wdata_i (ret_rd_wdata_i),
    .rec_valid_o    (rec_valid_o),
    .rec_ready_i    (rec_ready_i),
    .rec_o          (rec_o),
    .count_o        (count_o),
    .drop_count_o   (drop_count_o),
    .halt_seen_o    (halt_seen_o),
    .drained_o      (drained_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr,
                        input logic we, input logic [4:0] rd, input logic [31:0] wd);
    ret_valid_i    = 1'b1;
    ret_pc_i       = pc;
    ret_instr_i    = instr;
    ret_rd_we_i    = we;
    ret_rd_i       = rd;
    ret_rd_wdata_i = wd;
  endtask

  task automatic idle();
    ret_valid_i    = 1'b0;
    ret_pc_i       = '0;
    ret_instr_i    = '0;
    ret_rd_we_i    = 1'b0;
    ret_rd_i       = '0;
    ret_rd_wdata_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    enable_i    = 1'b1;
    rec_ready_i = 1'b0;
    rst         = 1'b0;
    idle();

    // ---- reset state
    do_reset();
    chk("rst_valid", 64'(rec_valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_drop", 64'(drop_count_o), 64'd0);
    chk("rst_halt", 64'(halt_seen_o), 64'd0);
    chk("rst_drained", 64'(drained_o), 64'd0);

    // ---- 1: three retires streamed straight through (cycles 0,1,2)
    rec_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      retire(32'(4 * i), ADDI1, 1'b1, 5'd1, 32'(i));
      tick();
      chk("t1_valid", 64'(rec_valid_o), 64'd1);
      chk("t1_pc", 64'(rec_o.pc), 64'(4 * i));
      chk("t1_seq", 64'(rec_o.seq), 64'(i));
      chk("t1_cycle", rec_o.cycle, 64'(i));
    end
    idle();
    tick();
    chk("t1_count_end", 64'(count_o), 64'd0);
    chk("t1_valid_end", 64'(rec_valid_o), 64'd0);
    // enable low: ignored, no seq consumed
    enable_i = 1'b0;
    retire(32'h50, ADDI1, 1'b1, 5'd1, 32'd9);
    tick();
    chk("t1_dis_count", 64'(count_o), 64'd0);
    enable_i = 1'b1;
    tick();
    idle();
    chk("t1_en_seq", 64'(rec_o.seq), 64'd3);
    tick();

    // ---- 2: overflow with ready low, 19 retires at cycles 0..18
    do_reset();
    rec_ready_i = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      retire(32'(32'h100 + 4 * i), ADDI1, 1'b1, 5'd1, 32'(i));
      tick();
    end
    idle();
    chk("t2_count_full", 64'(count_o), 64'd16);
    chk("t2_drops", 64'(drop_count_o), 64'd3);
    chk("t2_head_stable", 64'(rec_o.seq), 64'd0);
    rec_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2_seq", 64'(rec_o.seq), 64'(i));
      chk("t2_cycle", rec_o.cycle, 64'(i));
      chk("t2_pc", 64'(rec_o.pc), 64'(32'h100 + 4 * i));
      tick();
    end
    chk("t2_count_empty", 64'(count_o), 64'd0);
    rec_ready_i = 1'b0;
    retire(32'h200, ADDI1, 1'b1, 5'd1, 32'd0);
    tick();
    idle();
    chk("t2_next_seq", 64'(rec_o.seq), 64'd19);

    // ---- 3: full FIFO, push and pop together
    for (int i = 0; i < DEPTH - 1; i++) begin
      retire(32'(32'h204 + 4 * i), ADDI1, 1'b1, 5'd1, 32'(i));
      tick();
    end
    idle();
    chk("t3_full", 64'(count_o), 64'd16);
    retire(32'hABC0, ADDI1, 1'b1, 5'd1, 32'd7);
    rec_ready_i = 1'b1;
    tick();
    idle();
    rec_ready_i = 1'b0;
    chk("t3_count_same", 64'(count_o), 64'd16);
    chk("t3_no_drop", 64'(drop_count_o), 64'd3);
    chk("t3_new_head", 64'(rec_o.seq), 64'd20);
    rec_ready_i = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) tick();
    chk("t3_tail_seq", 64'(rec_o.seq), 64'd35);
    chk("t3_tail_pc", 64'(rec_o.pc), 64'hABC0);
    tick();
    chk("t3_empty", 64'(count_o), 64'd0);

    // ---- 4: x0 destination is sanitised
    rec_ready_i = 1'b0;
    retire(32'h300, 32'h0050_0013, 1'b1, 5'd0, 32'd5);
    tick();
    retire(32'h304, 32'h0050_0093, 1'b1, 5'd1, 32'd5);
    tick();
    idle();
    chk("t4_x0_we", 64'(rec_o.rd_we), 64'd0);
    chk("t4_x0_wdata", 64'(rec_o.wdata), 64'd0);
    rec_ready_i = 1'b1;
    tick();
    rec_ready_i = 1'b0;
    chk("t4_x1_we", 64'(rec_o.rd_we), 64'd1);
    chk("t4_x1_wdata", 64'(rec_o.wdata), 64'd5);
    rec_ready_i = 1'b1;
    tick();

    // ---- 5: ecall behind 4 queued entries, then drain to DONE
    do_reset();
    rec_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      retire(32'(4 * i), ADDI1, 1'b1, 5'd1, 32'(i));
      tick();
    end
    retire(32'h10, INSTR_ECALL, 1'b0, 5'd0, 32'd0);
    tick();
    chk("t5_halt_seen", 64'(halt_seen_o), 64'd1);
    chk("t5_count", 64'(count_o), 64'd5);
    retire(32'h14, ADDI1, 1'b1, 5'd1, 32'd1);
    tick();
    retire(32'h18, ADDI1, 1'b1, 5'd1, 32'd1);
    tick();
    idle();
    chk("t5_ignored_count", 64'(count_o), 64'd5);
    chk("t5_ignored_drop", 64'(drop_count_o), 64'd0);
    rec_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_seq", 64'(rec_o.seq), 64'(i));
      chk("t5_not_drained", 64'(drained_o), 64'd0);
      tick();
    end
    chk("t5_drained", 64'(drained_o), 64'd1);
    chk("t5_empty", 64'(rec_valid_o), 64'd0);
    retire(32'h20, ADDI1, 1'b1, 5'd1, 32'd1);
    tick();
    idle();
    tick();
    chk("t5_sticky", 64'(drained_o), 64'd1);
    chk("t5_done_count", 64'(count_o), 64'd0);

    // ---- 5b: ebreak dropped while full still halts
    do_reset();
    rec_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      retire(32'(4 * i), ADDI1, 1'b1, 5'd1, 32'(i));
      tick();
    end
    retire(32'h80, INSTR_EBREAK, 1'b0, 5'd0, 32'd0);
    tick();
    idle();
    chk("t5b_drop", 64'(drop_count_o), 64'd1);
    chk("t5b_halt", 64'(halt_seen_o), 64'd1);
    chk("t5b_count", 64'(count_o), 64'd16);

    // ---- 6: reset while in DRAIN with a full FIFO
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid", 64'(rec_valid_o), 64'd0);
    chk("t6_halt", 64'(halt_seen_o), 64'd0);
    chk("t6_count", 64'(count_o), 64'd0);
    chk("t6_drop", 64'(drop_count_o), 64'd0);
    retire(32'h400, ADDI1, 1'b1, 5'd1, 32'd3);
    tick();
    idle();
    chk("t6_accept", 64'(rec_valid_o), 64'd1);
    chk("t6_cycle", rec_o.cycle, 64'd0);
    chk("t6_seq", 64'(rec_o.seq), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
